// File: rtl/fx3_packet_sequencer_if.sv
// fx3_packet_sequencer_if: request, buffer-level and packet-status bundle between the FX3 side and the sequencer
interface fx3_packet_sequencer_if #(
  parameter int WORD_COUNT_WIDTH   = 16,
  parameter int LEVEL_WIDTH        = 14,
  parameter int PACKET_COUNT_WIDTH = 32
);
  logic                          readData;
  logic                          enable;
  logic [LEVEL_WIDTH-1:0]        fifoLevel;
  logic                          fx3isReading;
  logic [WORD_COUNT_WIDTH-1:0]   wordIndex;
  logic                          packetDone;
  logic                          packetAborted;
  logic [PACKET_COUNT_WIDTH-1:0] packetCount;
  logic                          underrunFlag;
  modport master (
    output readData, enable, fifoLevel,
    input  fx3isReading, wordIndex, packetDone, packetAborted, packetCount, underrunFlag
  );
  modport slave (
    input  readData, enable, fifoLevel,
    output fx3isReading, wordIndex, packetDone, packetAborted, packetCount, underrunFlag
  );
endinterface

// File: rtl/fx3_packet_sequencer.sv
// fx3_packet_sequencer: frames sample-buffer reads into fixed-size FX3 GPIF packets with gating, abort, gap and stats
module fx3_packet_sequencer #(
  parameter int PACKET_WORDS       = 8192,
  parameter int WORD_COUNT_WIDTH   = 16,
  parameter int LEVEL_WIDTH        = 14,
  parameter int GAP_CYCLES         = 0,
  parameter int PACKET_COUNT_WIDTH = 32
) (
  input logic                   fx3_clock,
  input logic                   nReset,
  fx3_packet_sequencer_if.slave bus
);
  // Common compare width so a narrow fifoLevel never truncates PACKET_WORDS
  localparam int CW = (LEVEL_WIDTH > 32) ? LEVEL_WIDTH : 32;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WORD_COUNT_WIDTH-1:0] LAST_WORD = WORD_COUNT_WIDTH'(PACKET_WORDS - 1);
  localparam logic [CW-1:0] PW = CW'(PACKET_WORDS);
  typedef enum logic [1:0] {WAIT_REQUEST, WAIT_DATA, SEND, GAP} state_t;
  localparam state_t EXIT = (GAP_CYCLES > 0) ? GAP : WAIT_REQUEST;
  state_t                        state_q, state_d;
  logic                          read_q;
  logic [WORD_COUNT_WIDTH-1:0]   idx_q, idx_d;
  logic [GW-1:0]                 gap_q, gap_d;
  logic                          done_q, done_d;
  logic                          abort_q, abort_d;
  logic [PACKET_COUNT_WIDTH-1:0] count_q, count_d;
  logic                          under_q, under_d;
  logic                          ready, last;
  assign ready = CW'(bus.fifoLevel) >= PW;
  assign last  = idx_q == LAST_WORD;
  // State register plus the single request synchroniser stage
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= WAIT_REQUEST;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= bus.readData;
    end
  end
  // Next-state: completion beats abort on the last word; enable only gates new packets
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_REQUEST: if (bus.enable && read_q) state_d = ready ? SEND : WAIT_DATA;
      WAIT_DATA:    if (!read_q || !bus.enable) state_d = WAIT_REQUEST;
                    else if (ready) state_d = SEND;
      SEND:         if (last || !read_q) state_d = EXIT;
      default:      if (gap_q == GAP_LAST) state_d = WAIT_REQUEST;
    endcase
  end
  // Output/datapath next values: word index, gap timer, pulses, counter, sticky underrun
  always_comb begin
    idx_d   = (state_q == SEND && state_d == SEND) ? idx_q + 1'b1 : '0;
    gap_d   = (state_q == GAP) ? gap_q + 1'b1 : '0;
    done_d  = state_q == SEND && last;
    abort_d = state_q == SEND && !last && !read_q;
    count_d = count_q + PACKET_COUNT_WIDTH'(done_d);
    under_d = !bus.enable ? 1'b0 :
              (state_q == WAIT_REQUEST && read_q && !ready) ? 1'b1 : under_q;
  end
  // Registered outputs and counters
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      idx_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
      under_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      count_q <= count_d;
      under_q <= under_d;
    end
  end
  assign bus.fx3isReading  = state_q == SEND;
  assign bus.wordIndex     = idx_q;
  assign bus.packetDone    = done_q;
  assign bus.packetAborted = abort_q;
  assign bus.packetCount   = count_q;
  assign bus.underrunFlag  = under_q;
endmodule

// File: tb/tb_fx3_packet_sequencer.sv
// tb_fx3_packet_sequencer: directed vector table plus hand sequences for the packet sequencer
module tb_fx3_packet_sequencer;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  fx3_packet_sequencer_if #(.WORD_COUNT_WIDTH(16), .LEVEL_WIDTH(14), .PACKET_COUNT_WIDTH(32)) b1 ();
  fx3_packet_sequencer_if #(.WORD_COUNT_WIDTH(16), .LEVEL_WIDTH(14), .PACKET_COUNT_WIDTH(4))  b5 ();
  fx3_packet_sequencer #(.PACKET_WORDS(16), .WORD_COUNT_WIDTH(16), .LEVEL_WIDTH(14),
                         .GAP_CYCLES(2), .PACKET_COUNT_WIDTH(32))
    dut (.fx3_clock(clk), .nReset(nReset), .bus(b1));
  fx3_packet_sequencer #(.PACKET_WORDS(16), .WORD_COUNT_WIDTH(16), .LEVEL_WIDTH(14),
                         .GAP_CYCLES(0), .PACKET_COUNT_WIDTH(4))
    dut5 (.fx3_clock(clk), .nReset(nReset), .bus(b5));
  typedef struct {
    logic        rd;
    logic        en;
    logic [13:0] lvl;
    logic        e_rd;
    logic [15:0] e_idx;
    logic        e_done;
    logic        e_abort;
    logic        e_und;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    b1.readData = 1'b0;
    b1.enable = 1'b1;
    b1.fifoLevel = 14'd100;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
  endtask
  task automatic wait_idx(input logic [15:0] target);
    int n = 0;
    while (b1.wordIndex != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait wordIndex", 32'(b1.wordIndex), 32'(target));
  endtask
  task automatic wait_rise1();
    int n = 0;
    while (!b1.fx3isReading && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait rise", 32'(b1.fx3isReading), 32'd1);
  endtask
  task automatic high_run1(output int hi);
    hi = 0;
    while (b1.fx3isReading && hi < 40) begin
      hi++;
      @(negedge clk);
    end
  endtask
  initial begin
    int hi, lo, n;
    v[0]  = '{1'b1, 1'b1, 14'd10, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b1, 14'd10, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    v[2]  = '{1'b1, 1'b1, 14'd15, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
    v[3]  = '{1'b1, 1'b1, 14'd16, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1};
    v[4]  = '{1'b1, 1'b1, 14'd16, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1};
    v[5]  = '{1'b1, 1'b0, 14'd16, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0};
    v[6]  = '{1'b0, 1'b1, 14'd16, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0};
    v[7]  = '{1'b0, 1'b1, 14'd16, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
    v[8]  = '{1'b0, 1'b1, 14'd16, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v[9]  = '{1'b0, 1'b1, 14'd16, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v[10] = '{1'b1, 1'b1, 14'd16, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v[11] = '{1'b1, 1'b1, 14'd16, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0};
    b5.readData = 1'b0;
    b5.enable = 1'b0;
    b5.fifoLevel = 14'd100;
    do_reset();
    @(negedge clk);
    chk("reset reading", 32'(b1.fx3isReading), 32'd0);
    chk("reset idx", 32'(b1.wordIndex), 32'd0);
    chk("reset done", 32'(b1.packetDone), 32'd0);
    chk("reset abort", 32'(b1.packetAborted), 32'd0);
    chk("reset count", b1.packetCount, 32'd0);
    chk("reset underrun", 32'(b1.underrunFlag), 32'd0);
    // continuous streaming with gap
    b1.readData = 1'b1;
    @(negedge clk);
    chk("latency edge1", 32'(b1.fx3isReading), 32'd0);
    @(negedge clk);
    chk("latency edge2", 32'(b1.fx3isReading), 32'd1);
    for (int p = 0; p < 3; p++) begin
      high_run1(hi);
      chk("stream high run", 32'(hi), 32'd16);
      chk("stream done pulse", 32'(b1.packetDone), 32'd1);
      chk("stream count", b1.packetCount, 32'(p + 1));
      @(negedge clk);
      chk("stream done width", 32'(b1.packetDone), 32'd0);
      lo = 1;
      while (!b1.fx3isReading && lo < 40) begin
        lo++;
        @(negedge clk);
      end
      chk("stream low run", 32'(lo), 32'd3);
    end
    // vector table: underrun, level boundary, enable clear, abort, restart
    do_reset();
    for (int i = 0; i < 12; i++) begin
      b1.readData = v[i].rd;
      b1.enable = v[i].en;
      b1.fifoLevel = v[i].lvl;
      @(negedge clk);
      chk($sformatf("vec%0d reading", i), 32'(b1.fx3isReading), 32'(v[i].e_rd));
      chk($sformatf("vec%0d idx", i), 32'(b1.wordIndex), 32'(v[i].e_idx));
      chk($sformatf("vec%0d done", i), 32'(b1.packetDone), 32'(v[i].e_done));
      chk($sformatf("vec%0d abort", i), 32'(b1.packetAborted), 32'(v[i].e_abort));
      chk($sformatf("vec%0d underrun", i), 32'(b1.underrunFlag), 32'(v[i].e_und));
    end
    chk("vec count", b1.packetCount, 32'd0);
    // abort at wordIndex 5
    do_reset();
    b1.readData = 1'b1;
    wait_idx(16'd5);
    b1.readData = 1'b0;
    @(negedge clk);
    chk("abort last idx", 32'(b1.wordIndex), 32'd6);
    chk("abort still reading", 32'(b1.fx3isReading), 32'd1);
    @(negedge clk);
    chk("abort reading", 32'(b1.fx3isReading), 32'd0);
    chk("abort pulse", 32'(b1.packetAborted), 32'd1);
    chk("abort no done", 32'(b1.packetDone), 32'd0);
    chk("abort idx zero", 32'(b1.wordIndex), 32'd0);
    @(negedge clk);
    chk("abort pulse width", 32'(b1.packetAborted), 32'd0);
    chk("abort count", b1.packetCount, 32'd0);
    // asynchronous reset mid-packet
    do_reset();
    b1.readData = 1'b1;
    wait_idx(16'd7);
    #2 nReset = 1'b0;
    #1;
    chk("async reading", 32'(b1.fx3isReading), 32'd0);
    chk("async idx", 32'(b1.wordIndex), 32'd0);
    chk("async count", b1.packetCount, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    wait_rise1();
    high_run1(hi);
    chk("post reset packet", 32'(hi), 32'd16);
    chk("post reset done", 32'(b1.packetDone), 32'd1);
    chk("post reset count", b1.packetCount, 32'd1);
    // enable dropped mid-packet: finishes, then no new packet
    do_reset();
    b1.readData = 1'b1;
    wait_idx(16'd3);
    b1.enable = 1'b0;
    high_run1(hi);
    chk("enable drop remaining", 32'(hi), 32'd13);
    chk("enable drop done", 32'(b1.packetDone), 32'd1);
    chk("enable drop count", b1.packetCount, 32'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b1.fx3isReading) n++;
    end
    chk("enable drop no restart", 32'(n), 32'd0);
    b1.readData = 1'b0;
    // narrow counter wrap, no gap
    b5.enable = 1'b1;
    b5.readData = 1'b1;
    n = 0;
    while (!b5.fx3isReading && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("nogap rise", 32'(b5.fx3isReading), 32'd1);
    for (int p = 0; p < 17; p++) begin
      hi = 0;
      while (b5.fx3isReading && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      if (p == 0 || p == 16) chk("nogap high run", 32'(hi), 32'd16);
      if (p == 16) chk("nogap wrap count", 32'(b5.packetCount), 32'd1);
      lo = 0;
      while (!b5.fx3isReading && lo < 40) begin
        lo++;
        @(negedge clk);
      end
      chk("nogap low run", 32'(lo), 32'd1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
